complete_stage: RTL and testbench

- Consumes the single FU_COMPLETE_PACKET the functional-unit cluster emits each cycle.
- Buffers results in a small in-order queue.
- Broadcasts one result per cycle on the CDB (RS wakeup, map table), writes the PRF, and marks the ROB entry complete.
- Back-pressures the FU cluster with stall when the queue is full.
- Flushes everything on a branch-mispredict squash.

---
 rtl/complete_stage_pkg.sv | 47 ++++
 rtl/complete_stage_if.sv | 34 +++
 rtl/complete_fifo.sv | 99 +++++++++
 rtl/complete_stage.sv | 100 ++++++++++
 tb/tb_complete_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/complete_stage_pkg.sv
// Shared types for the completion stage: FU result packets, CDB/PRF/ROB
// broadcast packets, index widths and the zero-register constant.
package complete_stage_pkg;

  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int PC_W      = 32;

  // Physical register 0 is hard-wired zero: never written, never woken up.
  localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } queue_state_e;

  typedef struct packed {
    logic                 valid;
    logic [PRF_IDX_W-1:0] pr_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    dest_value;
    logic                 take_branch;
    logic [PC_W-1:0]      target_pc;
  } FU_COMPLETE_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [PRF_IDX_W-1:0] pr_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
  } CDB_PACKET;

  typedef struct packed {
    logic                 en;
    logic [PRF_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    value;
  } FU_PRF_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 take_branch;
    logic [PC_W-1:0]      target_pc;
  } ROB_CMPL_PACKET;

endpackage

// File: rtl/complete_stage_if.sv
// Bundle of FU-side input, control inputs and broadcast outputs of the
// completion stage. The stage uses the slave view; its environment the master.
interface complete_stage_if;
  import complete_stage_pkg::*;

  FU_COMPLETE_PACKET fu_complete_in;
  logic              squash;
  logic              rob_ready;
  logic              stall_out;
  CDB_PACKET         cdb_out;
  FU_PRF_PACKET      prf_wr_out;
  ROB_CMPL_PACKET    rob_cmpl_out;

  modport slave (
    input  fu_complete_in,
    input  squash,
    input  rob_ready,
    output stall_out,
    output cdb_out,
    output prf_wr_out,
    output rob_cmpl_out
  );

  modport master (
    output fu_complete_in,
    output squash,
    output rob_ready,
    input  stall_out,
    input  cdb_out,
    input  prf_wr_out,
    input  rob_cmpl_out
  );

endinterface

// File: rtl/complete_fifo.sv
// In-order completion queue of FU_COMPLETE_PACKET entries with push, pop and
// flush. Occupancy is tracked by a count plus an EMPTY/PARTIAL/FULL state.
module complete_fifo
  import complete_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  FU_COMPLETE_PACKET         i_data,
  output FU_COMPLETE_PACKET         o_head,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int                 PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]     DEPTH_C = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]     ONE_C   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]   PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  FU_COMPLETE_PACKET r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic [PTR_W:0]    w_count_nxt;
  queue_state_e      r_state;
  queue_state_e      w_state_nxt;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  // A full queue ignores input even when it pops this cycle; flush wins over both.
  assign w_full  = (r_state == Q_FULL);
  assign o_empty = (r_state == Q_EMPTY);
  assign w_push  = i_push & ~w_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  // Next occupancy and queue state from push/pop/flush.
  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    if (i_flush) begin
      w_count_nxt = '0;
      w_state_nxt = Q_EMPTY;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + ONE_C;
        2'b01:   w_count_nxt = r_count - ONE_C;
        default: w_count_nxt = r_count;
      endcase
      unique case (r_state)
        Q_EMPTY: begin
          if (w_push) w_state_nxt = Q_PARTIAL;
        end
        Q_PARTIAL: begin
          if (w_push && !w_pop && (r_count + ONE_C == DEPTH_C))
            w_state_nxt = Q_FULL;
          else if (w_pop && !w_push && (r_count == ONE_C))
            w_state_nxt = Q_EMPTY;
        end
        Q_FULL: begin
          if (w_pop) w_state_nxt = Q_PARTIAL;
        end
        default: w_state_nxt = Q_EMPTY;
      endcase
    end
  end

  // Pointer, count and state registers; flush and reset empty the queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= Q_EMPTY;
    end else begin
      if (i_flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PTR_ONE;
        if (w_pop)  r_head <= r_head + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Entry storage; contents are only observed while the queue holds them.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_tail] <= i_data;
  end

endmodule

// File: rtl/complete_stage.sv
// Completion stage: queues FU results in order and broadcasts the head entry
// on the CDB, PRF write port and ROB completion port when the ROB is ready.
// Optional statistics counters are built when COMPLETE_STAGE_STATS_EN is defined.
module complete_stage
  import complete_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  complete_stage_if.slave      bus
`ifdef COMPLETE_STAGE_STATS_EN
  ,
  output logic [31:0]          cmpl_count,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          squash_drops
`endif
);

  localparam int             CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];

  FU_COMPLETE_PACKET w_head;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_push;
  logic              w_fire;
  logic              w_nonzero;

  // Squash drops the same-cycle input; stall is purely registered state.
  assign w_push         = bus.fu_complete_in.valid & ~bus.squash;
  assign bus.stall_out  = (w_count == DEPTH_C);
  assign w_fire         = ~w_empty & w_head.valid & bus.rob_ready & ~bus.squash;
  assign w_nonzero      = (w_head.pr_idx != ZERO_REG);

  complete_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_fire),
    .i_flush (bus.squash),
    .i_data  (bus.fu_complete_in),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Broadcast the head entry; the zero register only completes in the ROB.
  always_comb begin
    bus.cdb_out      = '0;
    bus.prf_wr_out   = '0;
    bus.rob_cmpl_out = '0;
    if (w_fire) begin
      bus.rob_cmpl_out.valid       = 1'b1;
      bus.rob_cmpl_out.rob_idx     = w_head.rob_idx;
      bus.rob_cmpl_out.take_branch = w_head.take_branch;
      bus.rob_cmpl_out.target_pc   = w_head.target_pc;
      if (w_nonzero) begin
        bus.cdb_out.valid    = 1'b1;
        bus.cdb_out.pr_idx   = w_head.pr_idx;
        bus.cdb_out.rob_idx  = w_head.rob_idx;
        bus.prf_wr_out.en    = 1'b1;
        bus.prf_wr_out.idx   = w_head.pr_idx;
        bus.prf_wr_out.value = w_head.dest_value;
      end
    end
  end

`ifdef COMPLETE_STAGE_STATS_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] r_cmpl_count;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_squash_drops;

  // Saturating event counters: broadcasts, stalled cycles, squashed entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cmpl_count   <= '0;
      r_stall_cycles <= '0;
      r_squash_drops <= '0;
    end else begin
      if (w_fire)        r_cmpl_count   <= sat_add32(r_cmpl_count, 32'd1);
      if (bus.stall_out) r_stall_cycles <= sat_add32(r_stall_cycles, 32'd1);
      if (bus.squash)    r_squash_drops <= sat_add32(r_squash_drops, 32'(w_count));
    end
  end

  assign cmpl_count   = r_cmpl_count;
  assign stall_cycles = r_stall_cycles;
  assign squash_drops = r_squash_drops;
`endif

endmodule

// File: tb/tb_complete_stage.sv
// Directed plus random bench for complete_stage against a queue-based model.
module tb_complete_stage;
  import complete_stage_pkg::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  complete_stage_if bus ();

`ifdef COMPLETE_STAGE_STATS_EN
  logic [31:0] cmpl_count, stall_cycles, squash_drops;
  logic [31:0] m_cmpl, m_stall, m_drops;
`endif

  complete_stage #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef COMPLETE_STAGE_STATS_EN
    ,
    .cmpl_count   (cmpl_count),
    .stall_cycles (stall_cycles),
    .squash_drops (squash_drops)
`endif
  );

  int checks = 0;
  int errors = 0;
  FU_COMPLETE_PACKET mq[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
`ifdef COMPLETE_STAGE_STATS_EN
    m_cmpl = 0; m_stall = 0; m_drops = 0;
`endif
  endtask

  // Compare all outputs with what the model says the current cycle shows.
  task automatic expect_outputs(input logic rdy, input logic sq);
    CDB_PACKET e_cdb;
    FU_PRF_PACKET e_prf;
    ROB_CMPL_PACKET e_rob;
    FU_COMPLETE_PACKET h;
    e_cdb = '0; e_prf = '0; e_rob = '0;
    if (mq.size() > 0 && rdy && !sq) begin
      h = mq[0];
      e_rob.valid = 1'b1; e_rob.rob_idx = h.rob_idx;
      e_rob.take_branch = h.take_branch; e_rob.target_pc = h.target_pc;
      if (h.pr_idx != 0) begin
        e_cdb.valid = 1'b1; e_cdb.pr_idx = h.pr_idx; e_cdb.rob_idx = h.rob_idx;
        e_prf.en = 1'b1; e_prf.idx = h.pr_idx; e_prf.value = h.dest_value;
      end
    end
    check("stall_out", 128'(bus.stall_out), 128'(mq.size() == DEPTH));
    check("cdb_out", 128'(bus.cdb_out), 128'(e_cdb));
    check("prf_wr_out", 128'(bus.prf_wr_out), 128'(e_prf));
    check("rob_cmpl_out", 128'(bus.rob_cmpl_out), 128'(e_rob));
`ifdef COMPLETE_STAGE_STATS_EN
    check("cmpl_count", 128'(cmpl_count), 128'(m_cmpl));
    check("stall_cycles", 128'(stall_cycles), 128'(m_stall));
    check("squash_drops", 128'(squash_drops), 128'(m_drops));
`endif
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model.
  task automatic step(input logic v, input logic [PRF_IDX_W-1:0] pr, input logic [ROB_IDX_W-1:0] rob,
                      input logic [31:0] val, input logic br, input logic [31:0] pc,
                      input logic rdy, input logic sq);
    FU_COMPLETE_PACKET p;
    int pre;
    p.valid = v; p.pr_idx = pr; p.rob_idx = rob; p.dest_value = val;
    p.take_branch = br; p.target_pc = pc;
    bus.fu_complete_in = p;
    bus.rob_ready = rdy;
    bus.squash = sq;
    #1;
    expect_outputs(rdy, sq);
    pre = mq.size();
`ifdef COMPLETE_STAGE_STATS_EN
    if (pre == DEPTH) m_stall++;
`endif
    if (sq) begin
`ifdef COMPLETE_STAGE_STATS_EN
      m_drops += 32'(pre);
`endif
      mq.delete();
    end else begin
      if (pre > 0 && rdy) begin
        void'(mq.pop_front());
`ifdef COMPLETE_STAGE_STATS_EN
        m_cmpl++;
`endif
      end
      if (v && pre != DEPTH) mq.push_back(p);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, 32'h0, 1'b0, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    bus.fu_complete_in = '0;
    bus.rob_ready = 1'b0;
    bus.squash = 1'b0;
    model_clear();
    #1;
    expect_outputs(1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Single push, visible the following cycle, then empty.
    step(1'b1, 6'd7, 5'd3, 32'h1234, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Five pushes while ROB is busy: fifth dropped, then in-order drain.
    for (int i = 0; i < 5; i++)
      step(1'b1, 6'(10 + i), 5'(i), 32'(32'hA000 + i), i[0], 32'(32'h400 + 4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Zero register: ROB completion only.
    step(1'b1, 6'd0, 5'd9, 32'hDEAD, 1'b1, 32'h8000, 1'b1, 1'b0);
    idle(1'b1);

    // Three queued entries squashed with a same-cycle input.
    for (int i = 0; i < 3; i++) step(1'b1, 6'(20 + i), 5'(i), 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 6'd30, 5'd7, 32'h77, 1'b0, 32'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Full queue: pop cycle ignores input, next cycle accepts it.
    for (int i = 0; i < 4; i++) step(1'b1, 6'(40 + i), 5'(i), 32'(100 + i), 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 6'd50, 5'd20, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 6'd51, 5'd21, 32'h501, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Asynchronous reset mid-drain with two entries queued.
    step(1'b1, 6'd60, 5'd1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 6'd61, 5'd2, 32'h601, 1'b0, 32'h0, 1'b0, 1'b0);
    bus.fu_complete_in = '0;
    bus.rob_ready = 1'b1;
    #1;
    expect_outputs(1'b1, 1'b0);
    #1 reset = 1'b0;
    model_clear();
    #1;
    expect_outputs(1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    idle(1'b1);
    idle(1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0,
           (($urandom % 4) == 0) ? 6'd0 : 6'($urandom),
           5'($urandom), $urandom, 1'($urandom), $urandom,
           ($urandom % 3) != 0, ($urandom % 20) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
